// File: rtl/fir_ctrl_pkg.sv
// Shared constants and state encoding for the FIR filter control sequencer.
// Widths here are shared with the filter datapath.
package fir_ctrl_pkg;

    localparam int NUM_TAPS  = 10;
    localparam int NUM_BANK  = 4;
    localparam int COEFF_W   = 16;
    localparam int MSEL_W    = 2;
    localparam int FIRIN_W   = 3;
    localparam int ADDR_W    = 6;
    localparam int TAIL_CYC  = 9;
    localparam int GAP_CYC   = 2;
    localparam int NUM_COEFF = NUM_TAPS * NUM_BANK;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_TAIL,
        S_LD_FETCH,
        S_LD_WR,
        S_LD_GAP
    } state_t;

    // ROM address advance that sticks at the last coefficient instead of wrapping.
    function automatic logic [ADDR_W-1:0] addr_sat_inc(input logic [ADDR_W-1:0] a);
        if (a >= ADDR_W'(NUM_COEFF - 1)) begin
            return ADDR_W'(NUM_COEFF - 1);
        end
        return a + 1'b1;
    endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Streams all coefficients from the synchronous ROM into the filter banks,
// one bank at a time: a fetch cycle, NUM_TAPS write cycles, then a short gap.
module fir_coeff_loader
    import fir_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [COEFF_W-1:0] rd_data_i,
    output logic               rd_en_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    output logic               wr_flag_o,
    output logic [COEFF_W-1:0] wr_data_o,
    output logic               done_o,
    output logic [MSEL_W-1:0]  msel_nxt_o,
    output state_t             state_nxt_o
);

    state_t              state_q, state_d;
    logic [MSEL_W-1:0]   bank_q, bank_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d, ptr_base;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_en_q, rd_en_d;
    logic                flag_q, flag_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        ptr_base    = '0;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
        flag_d      = 1'b0;
        done_d      = 1'b0;
        msel_nxt_o  = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LD_FETCH;
                    bank_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_LD_FETCH: begin
                state_d = S_LD_WR;
                cnt_d   = '0;
            end
            S_LD_WR: begin
                if (cnt_q == CNT_W'(NUM_TAPS - 1)) begin
                    cnt_d   = '0;
                    state_d = (bank_q == MSEL_W'(NUM_BANK - 1)) ? S_IDLE : S_LD_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LD_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = S_LD_FETCH;
                    cnt_d   = '0;
                    bank_d  = bank_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // One read per fetch cycle and per write cycle except the last, so the word
        // for write cycle t is always on the ROM output during that cycle.
        ptr_base = (state_q == S_IDLE) ? '0 : ptr_q;
        if (state_d == S_LD_FETCH ||
            (state_d == S_LD_WR && cnt_d != CNT_W'(NUM_TAPS - 1))) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_base;
            ptr_d     = addr_sat_inc(ptr_base);
        end

        flag_d     = (state_d == S_LD_WR);
        msel_nxt_o = flag_d ? bank_d : '0;
        done_d     = flag_d && (bank_d == MSEL_W'(NUM_BANK - 1)) &&
                     (cnt_d == CNT_W'(NUM_TAPS - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            bank_q    <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            flag_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            flag_q    <= flag_d;
            done_q    <= done_d;
        end
    end

    assign state_nxt_o = state_d;
    assign rd_en_o     = rd_en_q;
    assign rd_addr_o   = rd_addr_q;
    assign wr_flag_o   = flag_q;
    assign done_o      = done_q;
    // The ROM output register holds the data; a registered enable aligns it with the flag.
    assign wr_data_o   = flag_q ? rd_data_i : '0;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Sequencer for the reconfigurable FIR filter: per-sample read/MAC bursts and
// on-request coefficient loads, with dropped strobes reported as overruns.
module fir_seq_ctrl
    import fir_ctrl_pkg::*;
(
    input  logic               iClk12M,
    input  logic               iRsn,
    input  logic               iEnSample600k,
    input  logic [FIRIN_W-1:0] iFirInRaw,
    input  logic [MSEL_W-1:0]  iRdBankSel,
    input  logic               iCoeffLoadReq,
    input  logic [COEFF_W-1:0] iCoeffRdData,
    output logic               oCoeffRdEn,
    output logic [ADDR_W-1:0]  oCoeffRdAddr,
    output logic               oCoeffUpdateFlag,
    output logic [COEFF_W-1:0] oWtDtRam,
    output logic               oMemRdFlag,
    output logic [MSEL_W-1:0]  oModuleSel,
    output logic [FIRIN_W-1:0] oFirIn,
    output logic               oBusy,
    output logic               oLoadDone,
    output logic               oOverrun
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [MSEL_W-1:0]   bank_q, bank_d;
    logic                pend_q, pend_d;
    logic                memrd_q, memrd_d;
    logic [MSEL_W-1:0]   msel_q, msel_d;
    logic [FIRIN_W-1:0]  firin_q, firin_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;
    logic                accept, ld_start;
    logic [MSEL_W-1:0]   ld_msel_nxt;
    state_t              ld_state_nxt;

    fir_coeff_loader u_loader (
        .clk_i       (iClk12M),
        .rst_ni      (iRsn),
        .start_i     (ld_start),
        .rd_data_i   (iCoeffRdData),
        .rd_en_o     (oCoeffRdEn),
        .rd_addr_o   (oCoeffRdAddr),
        .wr_flag_o   (oCoeffUpdateFlag),
        .wr_data_o   (oWtDtRam),
        .done_o      (oLoadDone),
        .msel_nxt_o  (ld_msel_nxt),
        .state_nxt_o (ld_state_nxt)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bank_d   = bank_q;
        memrd_d  = 1'b0;
        msel_d   = '0;
        firin_d  = '0;
        ovr_d    = 1'b0;
        accept   = 1'b0;
        ld_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A strobe in the same cycle wins; the load request stays pending.
                if (iEnSample600k) begin
                    accept = 1'b1;
                end else if (pend_q || iCoeffLoadReq) begin
                    ld_start = 1'b1;
                    state_d  = ld_state_nxt;
                    msel_d   = ld_msel_nxt;
                end
            end
            S_RD: begin
                ovr_d = iEnSample600k;
                if (cnt_q == CNT_W'(NUM_TAPS - 1)) begin
                    state_d = S_TAIL;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    memrd_d = 1'b1;
                    msel_d  = bank_q;
                end
            end
            S_TAIL: begin
                if (cnt_q == CNT_W'(TAIL_CYC - 1)) begin
                    if (iEnSample600k) begin
                        accept = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    ovr_d = iEnSample600k;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LD_FETCH, S_LD_WR, S_LD_GAP: begin
                ovr_d   = iEnSample600k;
                state_d = ld_state_nxt;
                msel_d  = ld_msel_nxt;
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_RD;
            cnt_d   = '0;
            bank_d  = iRdBankSel;
            memrd_d = 1'b1;
            msel_d  = iRdBankSel;
            firin_d = iFirInRaw;
        end

        // Clearing on start means a request seen during a load triggers another load.
        pend_d = ld_start ? 1'b0 : (pend_q | iCoeffLoadReq);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bank_q  <= '0;
            pend_q  <= 1'b0;
            memrd_q <= 1'b0;
            msel_q  <= '0;
            firin_q <= '0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            memrd_q <= memrd_d;
            msel_q  <= msel_d;
            firin_q <= firin_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign oMemRdFlag = memrd_q;
    assign oModuleSel = msel_q;
    assign oFirIn     = firin_q;
    assign oBusy      = busy_q;
    assign oOverrun   = ovr_q;

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
- Sequencer that drives the control inputs of the reconfigurable FIR filter: iCoeffUpdateFlag, iMemRdFlag, iModuleSel, iWtDtRam, iFirIn.
- Per 600 kHz sample strobe: presents the 3-bit input sample and runs a 10-tap read/MAC burst on one module.
- On request: streams 40 coefficients from a synchronous coefficient ROM into the filter's 4 module banks, 10 per bank.
- Sits between the sample-rate front end and the filter; replaces hand-driven sequencing.

Parameters:
- NUM_TAPS, 10, taps per module; read-burst and bank-write length.
- NUM_BANK, 4, coefficient banks / modules.
- COEFF_W, 16, coefficient width.
- ADDR_W, 6, ROM address width; must satisfy 2^ADDR_W >= NUM_TAPS*NUM_BANK.
- TAIL_CYC, 9, MAC drain cycles after a read burst.
- GAP_CYC, 2, idle cycles between bank writes.

Ports:
- iClk12M  in  1  12 MHz clock.
- iRsn  in  1  asynchronous active-low reset.
- iEnSample600k  in  1  one-cycle sample strobe, every 20 clocks.
- iFirInRaw  in  3  input sample; sampled on the strobe cycle.
- iRdBankSel  in  2  module used for read bursts; latched on strobe acceptance.
- iCoeffLoadReq  in  1  level/pulse request for a full coefficient load.
- iCoeffRdData  in  COEFF_W  ROM data; valid 1 cycle after oCoeffRdEn.
- oCoeffRdEn  out  1  ROM read enable.
- oCoeffRdAddr  out  ADDR_W  ROM address.
- oCoeffUpdateFlag  out  1  to filter iCoeffUpdateFlag.
- oWtDtRam  out  COEFF_W  to filter iWtDtRam.
- oMemRdFlag  out  1  to filter iMemRdFlag.
- oModuleSel  out  2  to filter iModuleSel.
- oFirIn  out  3  to filter iFirIn.
- oBusy  out  1  high in any state but IDLE.
- oLoadDone  out  1  one-cycle pulse when the last coefficient is written.
- oOverrun  out  1  one-cycle pulse when a strobe is dropped.

Behaviour:
- Reset (async, iRsn=0): all outputs 0, state IDLE, pending-load latch cleared, counters cleared. Reset mid-burst or mid-load aborts immediately; no resume.
- All outputs are registered.
- States:
  - IDLE
  - RD: NUM_TAPS cycles
  - TAIL: TAIL_CYC cycles
  - LD_FETCH: 1 cycle of ROM latency
  - LD_WR: NUM_TAPS cycles
  - LD_GAP: GAP_CYC cycles
- Strobe accepted at edge E (in IDLE, or in the last TAIL cycle):
  - RD runs cycles E+1..E+10; oMemRdFlag=1 throughout; oModuleSel=latched iRdBankSel.
  - oFirIn=latched iFirInRaw in cycle E+1 only, 0 otherwise.
  - TAIL runs E+11..E+19, then IDLE; a 20-clock period sustains back-to-back samples.
- Strobe in any other RD/TAIL cycle, or in any LD_* state: sample ignored, oOverrun pulses the next cycle.
- iCoeffLoadReq sets the pending latch at any time.
  - Load starts only from IDLE with no strobe that same cycle; a simultaneous strobe wins and the load stays pending.
- Load sequence, bank b=0..3:
  - LD_FETCH issues oCoeffRdEn with addr b*NUM_TAPS.
  - LD_WR cycle t: oCoeffUpdateFlag=1, oModuleSel=b, oWtDtRam=ROM[b*NUM_TAPS+t]; the next address is prefetched each cycle, so there are no bubbles.
  - LD_GAP: flag=0, oWtDtRam=0.
  - After bank 3: oLoadDone pulses, latch clears, return to IDLE. No gap after the last bank.
- Outside LD_WR: oCoeffUpdateFlag=0 and oWtDtRam=0. Outside RD: oMemRdFlag=0.
- Address counter saturates at NUM_TAPS*NUM_BANK-1; it never wraps within a load.
- A request arriving during a load is re-latched and triggers a second full load afterwards.

Decomposition:
- Shared package fir_ctrl_pkg holds:
  - state enum
  - NUM_TAPS, NUM_BANK, TAIL_CYC, GAP_CYC
  - COEFF_W and module-select width constants (shared with the filter)
- One sub-module, fir_coeff_loader: owns LD_FETCH/LD_WR/LD_GAP, the address counter and ROM prefetch. It is handed start/done by the top FSM.

Test Plan:
- Reset, then strobes every 20 clocks with iFirInRaw=3'b001 then 0, iRdBankSel=0 -> per strobe: oMemRdFlag high exactly 10 cycles; oFirIn=001 only on the first; no oOverrun.
- iCoeffLoadReq in IDLE, ROM[k]=16'h0A00+k (bank 0), 0x0B00.. (bank 1), 0x0C00.. (bank 2), 0x0D00.. (bank 3) -> 4 runs of 10 flag-high cycles, oModuleSel 0..3, oWtDtRam 0x0A00..0x0A09 … 0x0D00..0x0D09, 2-cycle gaps; oLoadDone once.
- Strobe and iCoeffLoadReq in the same IDLE cycle -> read burst first; load starts after TAIL ends.
- Strobe during LD_WR -> oOverrun pulse; no oMemRdFlag; load data unaffected.
- Extra strobe 7 cycles after an accepted one -> oOverrun; burst length is still 10.
- Assert iRsn=0 mid-load at bank 2, tap 4 -> all outputs 0 asynchronously; after release, no flags until a new request or strobe.
